// File: rtl/instr_queue.sv
// Instruction queue between fetch and decode: circular buffer with a registered
// decoder-side output stage, flush on redirect, and a global ready freeze.
module instr_queue #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              update_stat,
  input  logic              fetch_valid,
  input  logic [31:0]       fetch_instr,
  input  logic [31:0]       fetch_pc,
  output logic              fetch_ready,
  input  logic              stall,
  output logic              decode_enable,
  output logic [31:0]       instr,
  output logic [31:0]       pc,
  output logic [ADDR_W:0]   count
);

  logic [63:0]       r_mem [DEPTH];
  logic [ADDR_W-1:0] r_head;
  logic [ADDR_W-1:0] r_tail;
  logic [ADDR_W:0]   r_count;
  logic              r_dec_en;
  logic [31:0]       r_instr;
  logic [31:0]       r_pc;

  logic w_push;
  logic w_pop;
  logic w_not_full;

  // DEPTH is a power of two, so full is exactly the count MSB; depends only on registered count
  assign w_not_full = ~r_count[ADDR_W];
  assign w_push     = rdy & rst & ~update_stat & fetch_valid & w_not_full;
  assign w_pop      = rdy & rst & ~update_stat & ~stall & (r_count != '0);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_tail] <= {fetch_instr, fetch_pc};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_dec_en <= 1'b0;
      r_instr  <= '0;
      r_pc     <= '0;
    end else if (rdy) begin
      if (update_stat) begin
        r_head   <= '0;
        r_tail   <= '0;
        r_count  <= '0;
        r_dec_en <= 1'b0;
      end else begin
        if (w_push) r_tail <= r_tail + ADDR_W'(1);
        if (w_pop) begin
          r_instr  <= r_mem[r_head][63:32];
          r_pc     <= r_mem[r_head][31:0];
          r_dec_en <= 1'b1;
          r_head   <= r_head + ADDR_W'(1);
        end else begin
          r_dec_en <= 1'b0;
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + (ADDR_W+1)'(1);
          2'b01:   r_count <= r_count - (ADDR_W+1)'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  assign fetch_ready   = w_not_full;
  assign decode_enable = r_dec_en;
  assign instr         = r_instr;
  assign pc            = r_pc;
  assign count         = r_count;

endmodule

// File: tb/tb_instr_queue.sv
// Bench for instr_queue: directed scenarios plus random traffic, every cycle
// compared against a queue-based reference model of the fetch/decode contract.
module tb_instr_queue;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              rst, rdy, update_stat, fetch_valid, stall;
  logic [31:0]       fetch_instr, fetch_pc;
  logic              fetch_ready, decode_enable;
  logic [31:0]       instr, pc;
  logic [ADDR_W:0]   count;

  int total = 0;
  int bad   = 0;

  logic [63:0] q[$];
  logic        m_dec   = 1'b0;
  logic [31:0] m_instr = '0;
  logic [31:0] m_pc    = '0;

  instr_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .update_stat(update_stat),
    .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_pc(fetch_pc),
    .fetch_ready(fetch_ready), .stall(stall), .decode_enable(decode_enable),
    .instr(instr), .pc(pc), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic rd, input logic fl, input logic fv,
                       input logic st, input logic [31:0] iw, input logic [31:0] p);
    rst = r; rdy = rd; update_stat = fl; fetch_valid = fv; stall = st;
    fetch_instr = iw; fetch_pc = p;
  endtask

  // Reference model: a plain FIFO of {instr,pc}; occupancy checked before the edge.
  task automatic model_edge();
    logic [63:0] e;
    bit do_push, do_pop;
    if (!rst) begin
      q.delete(); m_dec = 1'b0; m_instr = '0; m_pc = '0;
    end else if (rdy) begin
      if (update_stat) begin
        q.delete(); m_dec = 1'b0;
      end else begin
        do_push = fetch_valid && (q.size() < DEPTH);
        do_pop  = !stall && (q.size() > 0);
        if (do_pop) begin
          e = q.pop_front(); m_instr = e[63:32]; m_pc = e[31:0]; m_dec = 1'b1;
        end else begin
          m_dec = 1'b0;
        end
        if (do_push) q.push_back({fetch_instr, fetch_pc});
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    chk("count", 32'(count), 32'(q.size()));
    chk("fetch_ready", 32'(fetch_ready), 32'(q.size() < DEPTH));
    chk("decode_enable", 32'(decode_enable), 32'(m_dec));
    chk("instr", instr, m_instr);
    chk("pc", pc, m_pc);
  endtask

  initial begin
    drive(0, 1, 0, 0, 0, 0, 0);
    cyc(); cyc();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ready", 32'(fetch_ready), 32'd1);

    // single instruction: strobe two edges after the push
    drive(1, 1, 0, 1, 0, 32'h00500093, 32'h0);
    cyc();
    chk("single_no_bypass", 32'(decode_enable), 32'd0);
    drive(1, 1, 0, 0, 0, 0, 0);
    cyc();
    chk("single_strobe", 32'(decode_enable), 32'd1);
    chk("single_instr", instr, 32'h00500093);
    chk("single_count", 32'(count), 32'd0);
    cyc();
    chk("single_strobe_end", 32'(decode_enable), 32'd0);

    // fill under stall, reject ninth, then pop-at-full rejects the push
    for (int i = 0; i < 8; i++) begin
      drive(1, 1, 0, 1, 1, $urandom, 32'(i * 4));
      cyc();
    end
    chk("full_count", 32'(count), 32'd8);
    chk("full_ready", 32'(fetch_ready), 32'd0);
    drive(1, 1, 0, 1, 1, 32'hDEADBEEF, 32'h20);
    cyc();
    chk("ninth_rejected", 32'(count), 32'd8);
    drive(1, 1, 0, 1, 0, 32'hCAFEF00D, 32'h24);
    cyc();
    chk("full_pop_count", 32'(count), 32'd7);
    chk("full_pop_pc", pc, 32'h0);
    for (int i = 1; i < 8; i++) begin
      drive(1, 1, 0, 0, 0, 0, 0);
      cyc();
      chk("drain_pc", pc, 32'(i * 4));
    end
    cyc();

    // continuous stream across pointer wrap
    for (int i = 0; i < 20; i++) begin
      drive(1, 1, 0, 1, 0, $urandom, 32'(i * 4));
      cyc();
    end
    drive(1, 1, 0, 0, 0, 0, 0);
    cyc();
    chk("wrap_last_pc", pc, 32'h4C);
    cyc();

    // flush with count=5 and a same-cycle fetch
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 0, 1, 1, $urandom, 32'h40 + 32'(i * 4));
      cyc();
    end
    drive(1, 1, 1, 1, 0, 32'h11111111, 32'h200);
    cyc();
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_dec", 32'(decode_enable), 32'd0);
    chk("flush_ready", 32'(fetch_ready), 32'd1);
    drive(1, 1, 0, 1, 0, 32'h22222222, 32'h100);
    cyc();
    drive(1, 1, 0, 0, 0, 0, 0);
    cyc();
    chk("post_flush_pc", pc, 32'h100);
    cyc();

    // rdy low freezes everything, including a live strobe
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 1, 1, $urandom, 32'h300 + 32'(i * 4));
      cyc();
    end
    drive(1, 1, 0, 0, 0, 0, 0);
    cyc();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 1, 1, 0, $urandom, 32'h900);
      cyc();
    end
    chk("freeze_dec", 32'(decode_enable), 32'd1);
    chk("freeze_count", 32'(count), 32'd2);
    drive(1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc();

    // reset mid-operation, with rdy low
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 0, 1, 1, $urandom, 32'h500 + 32'(i * 4));
      cyc();
    end
    drive(1, 1, 0, 0, 0, 0, 0);
    cyc();
    drive(0, 0, 0, 1, 0, 0, 0);
    cyc();
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_pc", pc, 32'd0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 49) != 0), ($urandom_range(0, 4) != 0),
            ($urandom_range(0, 15) == 0), ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 9) < 4), $urandom, $urandom);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
